// File: rtl/pc_rx_pkg.sv
// Shared types and constants for the PC RX deframer: FSM states, response codes,
// field sizes and the CRC-32/IEEE byte-update helper.
package pc_rx_pkg;

    typedef enum logic [1:0] {
        StHunt,
        StHdr,
        StPay,
        StCrc
    } state_e;

    localparam logic [2:0] RESP_CRC_ERR   = 3'd0;
    localparam logic [2:0] RESP_OK        = 3'd1;
    localparam logic [2:0] RESP_LEN_ERR   = 3'd2;
    localparam logic [2:0] RESP_OVERFLOW  = 3'd3;
    localparam logic [2:0] RESP_TIMEOUT   = 3'd4;
    localparam logic [2:0] RESP_FIFO_FULL = 3'd5;

    localparam int unsigned HDR_BYTES = 8;
    localparam int unsigned CRC_BYTES = 4;

    localparam logic [31:0] CRC_POLY   = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT   = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_XOROUT = 32'hFFFFFFFF;

    // Reflected CRC: LSB of the data byte enters first.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'b0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/pc_crc32_byte.sv
// Byte-wide CRC-32 accumulator with clear and enable; exposes the value the
// register will hold after the current cycle.
module pc_crc32_byte
    import pc_rx_pkg::*;
(
    input  logic        clk_sys,
    input  logic        rst,
    input  logic        clr_i,
    input  logic        en_i,
    input  logic [7:0]  data_i,
    output logic [31:0] crc_next_o
);

    logic [31:0] crc_q;

    always_comb begin
        crc_next_o = crc_q;
        if (clr_i) begin
            crc_next_o = CRC_INIT;
        end else if (en_i) begin
            crc_next_o = crc32_byte(crc_q, data_i);
        end
    end

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            crc_q <= CRC_INIT;
        end else begin
            crc_q <= crc_next_o;
        end
    end

endmodule

// File: rtl/pc_rx_deframe_mc.sv
// Multi-channel PC RX deframer: sync hunt, header parse, ring-buffer payload write,
// CRC/length/space/timeout checks, per-type info FIFO commit and response descriptor.
module pc_rx_deframe_mc
    import pc_rx_pkg::*;
#(
    parameter logic [31:0] SYNC_WORD   = 32'hEF9119FE,
    parameter int unsigned ADDR_W      = 12,
    parameter int unsigned NUM_CH      = 2,
    parameter logic [31:0] MAX_LEN     = 32'd4108,
    parameter int unsigned TIMEOUT_CYC = 100000
) (
    input  logic              clk_sys,
    input  logic              rst,
    input  logic [7:0]        pc_rx_data,
    input  logic              pc_rx_data_valid,
    input  logic [ADDR_W-1:0] fdram_rd_ptr,
    input  logic [NUM_CH-1:0] fififo_full,
    output logic              fdram_wr_en,
    output logic [ADDR_W-1:0] fdram_wr_addr,
    output logic [7:0]        fdram_wr_data,
    output logic [NUM_CH-1:0] fififo_wr_en,
    output logic [71:0]       fififo_wr_data,
    output logic [19:0]       resp_info,
    output logic              resp_info_valid
);

    localparam int unsigned    TO_W    = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
    localparam logic [31:0]    MIN_LEN = 32'(HDR_BYTES + CRC_BYTES);

    state_e              state_q, state_d;
    logic [23:0]         shift_q, shift_d;
    logic [23:0]         hdr_sh_q, hdr_sh_d;
    logic [23:0]         crc_rx_q, crc_rx_d;
    logic [31:0]         cnt_q, cnt_d;
    logic [15:0]         type_q, type_d;
    logic [31:0]         len_q, len_d;
    logic [15:0]         func_q, func_d;
    logic [TO_W-1:0]     idle_q, idle_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [ADDR_W-1:0]   commit_ptr_q, commit_ptr_d;
    logic [ADDR_W-1:0]   start_q, start_d;

    logic                fdram_wr_en_d;
    logic [ADDR_W-1:0]   fdram_wr_addr_d;
    logic [7:0]          fdram_wr_data_d;
    logic [NUM_CH-1:0]   fififo_wr_en_d;
    logic [71:0]         fififo_wr_data_d;
    logic [19:0]         resp_info_d;
    logic                resp_info_valid_d;

    logic                crc_clr, crc_en;
    logic [31:0]         crc_next;
    logic [NUM_CH-1:0]   ch_oh;
    logic                type_ok;
    logic                done, commit, emit;
    logic [2:0]          status;
    logic [31:0]         len_v, pay_n, rx_crc;
    logic [ADDR_W-1:0]   free_v;

    pc_crc32_byte u_crc (
        .clk_sys    (clk_sys),
        .rst        (rst),
        .clr_i      (crc_clr),
        .en_i       (crc_en),
        .data_i     (pc_rx_data),
        .crc_next_o (crc_next)
    );

    always_comb begin
        ch_oh = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            ch_oh[k] = (32'(type_q) == 32'(k + 1));
        end
        type_ok = |ch_oh;
        len_v   = {hdr_sh_q, pc_rx_data};
        pay_n   = len_q - MIN_LEN;
        rx_crc  = {crc_rx_q, pc_rx_data};
        // Free bytes keep one slot empty so full and empty are distinguishable.
        free_v  = ~(wr_addr_q - fdram_rd_ptr);
    end

    always_comb begin
        state_d           = state_q;
        shift_d           = shift_q;
        hdr_sh_d          = hdr_sh_q;
        crc_rx_d          = crc_rx_q;
        cnt_d             = cnt_q;
        type_d            = type_q;
        len_d             = len_q;
        func_d            = func_q;
        idle_d            = idle_q;
        wr_addr_d         = wr_addr_q;
        commit_ptr_d      = commit_ptr_q;
        start_d           = start_q;
        fdram_wr_en_d     = 1'b0;
        fdram_wr_addr_d   = fdram_wr_addr;
        fdram_wr_data_d   = fdram_wr_data;
        fififo_wr_en_d    = '0;
        fififo_wr_data_d  = fififo_wr_data;
        resp_info_d       = resp_info;
        resp_info_valid_d = 1'b0;
        crc_clr           = 1'b0;
        crc_en            = 1'b0;
        done              = 1'b0;
        commit            = 1'b0;
        emit              = 1'b0;
        status            = RESP_OK;

        if (pc_rx_data_valid) begin
            idle_d = '0;
            unique case (state_q)
                StHunt: begin
                    if ({shift_q, pc_rx_data} == SYNC_WORD) begin
                        state_d = StHdr;
                        shift_d = '0;
                        cnt_d   = '0;
                        type_d  = '0;
                        len_d   = '0;
                        func_d  = '0;
                        crc_clr = 1'b1;
                    end else begin
                        shift_d = {shift_q[15:0], pc_rx_data};
                    end
                end
                StHdr: begin
                    crc_en   = 1'b1;
                    hdr_sh_d = {hdr_sh_q[15:0], pc_rx_data};
                    cnt_d    = cnt_q + 32'd1;
                    if (cnt_q == 32'd1) begin
                        type_d = {hdr_sh_q[7:0], pc_rx_data};
                    end
                    if (cnt_q == 32'd5) begin
                        len_d = len_v;
                        if (len_v < MIN_LEN || len_v > MAX_LEN) begin
                            done   = 1'b1;
                            emit   = type_ok;
                            status = RESP_LEN_ERR;
                        end
                    end
                    if (cnt_q == 32'(HDR_BYTES - 1)) begin
                        func_d  = {hdr_sh_q[7:0], pc_rx_data};
                        start_d = wr_addr_q;
                        cnt_d   = '0;
                        if (pay_n > 32'(free_v)) begin
                            done   = 1'b1;
                            emit   = type_ok;
                            status = RESP_OVERFLOW;
                        end else if (pay_n == 32'd0) begin
                            state_d = StCrc;
                        end else begin
                            state_d = StPay;
                            cnt_d   = pay_n;
                        end
                    end
                end
                StPay: begin
                    crc_en          = 1'b1;
                    fdram_wr_en_d   = 1'b1;
                    fdram_wr_addr_d = wr_addr_q;
                    fdram_wr_data_d = pc_rx_data;
                    wr_addr_d       = wr_addr_q + 1'b1;
                    cnt_d           = cnt_q - 32'd1;
                    if (cnt_q == 32'd1) begin
                        state_d = StCrc;
                        cnt_d   = '0;
                    end
                end
                StCrc: begin
                    crc_rx_d = {crc_rx_q[15:0], pc_rx_data};
                    cnt_d    = cnt_q + 32'd1;
                    if (cnt_q == 32'(CRC_BYTES - 1)) begin
                        done = 1'b1;
                        emit = type_ok;
                        if (rx_crc != (crc_next ^ CRC_XOROUT)) begin
                            status = RESP_CRC_ERR;
                        end else if (|(ch_oh & fififo_full)) begin
                            status = RESP_FIFO_FULL;
                        end else if (type_ok) begin
                            commit           = 1'b1;
                            fififo_wr_en_d   = ch_oh;
                            fififo_wr_data_d = {func_q, 16'(start_q), 8'h80, len_q};
                            commit_ptr_d     = wr_addr_q;
                        end
                    end
                end
                default: state_d = StHunt;
            endcase
        end else if (state_q != StHunt) begin
            if (idle_q == TO_LAST) begin
                done   = 1'b1;
                emit   = type_ok;
                status = RESP_TIMEOUT;
                idle_d = '0;
            end else begin
                idle_d = idle_q + 1'b1;
            end
        end

        if (done) begin
            state_d = StHunt;
            shift_d = '0;
            cnt_d   = '0;
            if (!commit) begin
                wr_addr_d = commit_ptr_q;
            end
        end
        if (emit) begin
            resp_info_valid_d = 1'b1;
            resp_info_d       = {1'b0, status, func_d};
        end
    end

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            state_q         <= StHunt;
            shift_q         <= '0;
            hdr_sh_q        <= '0;
            crc_rx_q        <= '0;
            cnt_q           <= '0;
            type_q          <= '0;
            len_q           <= '0;
            func_q          <= '0;
            idle_q          <= '0;
            wr_addr_q       <= '0;
            commit_ptr_q    <= '0;
            start_q         <= '0;
            fdram_wr_en     <= 1'b0;
            fdram_wr_addr   <= '0;
            fdram_wr_data   <= '0;
            fififo_wr_en    <= '0;
            fififo_wr_data  <= '0;
            resp_info       <= '0;
            resp_info_valid <= 1'b0;
        end else begin
            state_q         <= state_d;
            shift_q         <= shift_d;
            hdr_sh_q        <= hdr_sh_d;
            crc_rx_q        <= crc_rx_d;
            cnt_q           <= cnt_d;
            type_q          <= type_d;
            len_q           <= len_d;
            func_q          <= func_d;
            idle_q          <= idle_d;
            wr_addr_q       <= wr_addr_d;
            commit_ptr_q    <= commit_ptr_d;
            start_q         <= start_d;
            fdram_wr_en     <= fdram_wr_en_d;
            fdram_wr_addr   <= fdram_wr_addr_d;
            fdram_wr_data   <= fdram_wr_data_d;
            fififo_wr_en    <= fififo_wr_en_d;
            fififo_wr_data  <= fififo_wr_data_d;
            resp_info       <= resp_info_d;
            resp_info_valid <= resp_info_valid_d;
        end
    end

endmodule

// File: tb/tb_pc_rx_deframe_mc.sv
// Scoreboard bench for pc_rx_deframe_mc: directed frames push expected RAM writes,
// FIFO writes and responses; a negedge monitor pops and compares.
module tb_pc_rx_deframe_mc;

    localparam int AW = 4;
    localparam int NC = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    pc_rx_data;
    logic          pc_rx_data_valid;
    logic [AW-1:0] fdram_rd_ptr;
    logic [NC-1:0] fififo_full;
    logic          fdram_wr_en;
    logic [AW-1:0] fdram_wr_addr;
    logic [7:0]    fdram_wr_data;
    logic [NC-1:0] fififo_wr_en;
    logic [71:0]   fififo_wr_data;
    logic [19:0]   resp_info;
    logic          resp_info_valid;

    pc_rx_deframe_mc #(
        .SYNC_WORD   (32'hEF9119FE),
        .ADDR_W      (AW),
        .NUM_CH      (NC),
        .MAX_LEN     (32'd4108),
        .TIMEOUT_CYC (40)
    ) dut (
        .clk_sys          (clk),
        .rst              (rst),
        .pc_rx_data       (pc_rx_data),
        .pc_rx_data_valid (pc_rx_data_valid),
        .fdram_rd_ptr     (fdram_rd_ptr),
        .fififo_full      (fififo_full),
        .fdram_wr_en      (fdram_wr_en),
        .fdram_wr_addr    (fdram_wr_addr),
        .fdram_wr_data    (fdram_wr_data),
        .fififo_wr_en     (fififo_wr_en),
        .fififo_wr_data   (fififo_wr_data),
        .resp_info        (resp_info),
        .resp_info_valid  (resp_info_valid)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0]  frame_q[$];
    logic [7:0]  pay_q[$];
    logic [19:0] resp_q[$];
    logic [73:0] fifo_q[$];
    logic [11:0] wr_q[$];

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [79:0] act);
        n_checks++;
        $display("FAIL %s: got unexpected output %0h expected none", name, act);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (resp_info_valid) begin
                if (resp_q.size() == 0) unexpected("resp", 80'(resp_info));
                else check("resp", 80'(resp_info), 80'(resp_q.pop_front()));
            end
            if (fififo_wr_en != '0) begin
                if (fifo_q.size() == 0) unexpected("fifo_wr", 80'({fififo_wr_en, fififo_wr_data}));
                else check("fifo_wr", 80'({fififo_wr_en, fififo_wr_data}), 80'(fifo_q.pop_front()));
            end
            if (fdram_wr_en) begin
                if (wr_q.size() == 0) unexpected("ram_wr", 80'({fdram_wr_addr, fdram_wr_data}));
                else check("ram_wr", 80'({fdram_wr_addr, fdram_wr_data}), 80'(wr_q.pop_front()));
            end
        end
    end

    function automatic logic [31:0] crc_upd(input logic [31:0] c_in, input logic [7:0] d);
        logic [31:0] c;
        c = c_in ^ {24'b0, d};
        for (int i = 0; i < 8; i++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        return c;
    endfunction

    // Frame = sync, TYPE, LEN, FUNC, pay_q, CRC (optionally with LSB flipped).
    task automatic build(input logic [15:0] typ, input logic [15:0] fn, input logic [31:0] len,
                         input bit bad);
        logic [31:0] c;
        frame_q = {8'hEF, 8'h91, 8'h19, 8'hFE, typ[15:8], typ[7:0],
                   len[31:24], len[23:16], len[15:8], len[7:0], fn[15:8], fn[7:0]};
        foreach (pay_q[i]) frame_q.push_back(pay_q[i]);
        c = 32'hFFFFFFFF;
        for (int i = 4; i < frame_q.size(); i++) c = crc_upd(c, frame_q[i]);
        c = c ^ 32'hFFFFFFFF;
        frame_q.push_back(c[31:24]);
        frame_q.push_back(c[23:16]);
        frame_q.push_back(c[15:8]);
        frame_q.push_back(c[7:0] ^ {7'b0, bad});
    endtask

    task automatic push_writes(input int start, input int cnt);
        for (int i = 0; i < cnt; i++) wr_q.push_back({AW'(start + i), pay_q[i]});
    endtask

    task automatic send_n(input int cnt);
        for (int i = 0; i < cnt; i++) begin
            @(negedge clk);
            pc_rx_data       = frame_q[i];
            pc_rx_data_valid = 1'b1;
            @(negedge clk);
            pc_rx_data_valid = 1'b0;
        end
    endtask

    task automatic send_all();
        send_n(frame_q.size());
        repeat (3) @(negedge clk);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_wr_en"},   80'(fdram_wr_en), 80'(0));
        check({tag, "_wr_addr"}, 80'(fdram_wr_addr), 80'(0));
        check({tag, "_wr_data"}, 80'(fdram_wr_data), 80'(0));
        check({tag, "_fifo_en"}, 80'(fififo_wr_en), 80'(0));
        check({tag, "_fifo_dt"}, 80'(fififo_wr_data), 80'(0));
        check({tag, "_resp"},    80'(resp_info), 80'(0));
        check({tag, "_resp_v"},  80'(resp_info_valid), 80'(0));
    endtask

    initial begin
        rst              = 1'b1;
        pc_rx_data       = '0;
        pc_rx_data_valid = 1'b0;
        fdram_rd_ptr     = '0;
        fififo_full      = '0;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        rst = 1'b0;

        // Bad CRC: payload written then discarded, pointer back to 0.
        pay_q = {8'h11, 8'h22, 8'h33, 8'h44};
        build(16'h0001, 16'h1234, 32'd16, 1'b1);
        push_writes(0, 4);
        resp_q.push_back(20'h01234);
        send_all();

        // Same frame, good CRC, must land at address 0 again.
        build(16'h0001, 16'h1234, 32'd16, 1'b0);
        push_writes(0, 4);
        fifo_q.push_back({2'b01, 16'h1234, 16'h0000, 8'h80, 32'h00000010});
        resp_q.push_back(20'h11234);
        send_all();
        fdram_rd_ptr = 4'd4;

        // LEN below minimum: abort right after the LEN field.
        pay_q = {};
        build(16'h0001, 16'h0000, 32'h0000000B, 1'b0);
        resp_q.push_back(20'h20000);
        send_n(10);
        repeat (3) @(negedge clk);

        // Channel 2, sync pattern embedded in payload treated as data.
        pay_q = {8'hEF, 8'h91, 8'h19, 8'hFE, 8'h01, 8'h02};
        build(16'h0002, 16'h0055, 32'd18, 1'b0);
        push_writes(4, 6);
        fifo_q.push_back({2'b10, 16'h0055, 16'h0004, 8'h80, 32'd18});
        resp_q.push_back(20'h10055);
        send_all();
        fdram_rd_ptr = 4'd10;

        pay_q = {8'hC1, 8'hC2};
        build(16'h0001, 16'h0006, 32'd14, 1'b0);
        push_writes(10, 2);
        fifo_q.push_back({2'b01, 16'h0006, 16'h000A, 8'h80, 32'd14});
        resp_q.push_back(20'h10006);
        send_all();

        // wr_addr=12, rd_ptr=0: free=3 < N=4 -> overflow.
        fdram_rd_ptr = 4'd0;
        pay_q = {8'hA1, 8'hA2, 8'hA3, 8'hA4};
        build(16'h0001, 16'h0A0A, 32'd16, 1'b0);
        resp_q.push_back(20'h30A0A);
        send_n(12);
        repeat (3) @(negedge clk);

        // rd_ptr=8: free=11, N=8 wraps 12..15,0..3.
        fdram_rd_ptr = 4'd8;
        pay_q = {8'hB0, 8'hB1, 8'hB2, 8'hB3, 8'hB4, 8'hB5, 8'hB6, 8'hB7};
        build(16'h0001, 16'h0808, 32'd20, 1'b0);
        push_writes(12, 8);
        fifo_q.push_back({2'b01, 16'h0808, 16'h000C, 8'h80, 32'd20});
        resp_q.push_back(20'h10808);
        send_all();
        fdram_rd_ptr = 4'd4;

        // Stall mid-payload past the timeout.
        pay_q = {8'hC0, 8'hC1, 8'hC2, 8'hC3};
        build(16'h0001, 16'h0505, 32'd16, 1'b0);
        push_writes(4, 2);
        resp_q.push_back(20'h40505);
        send_n(14);
        repeat (60) @(negedge clk);

        pay_q = {8'h5A};
        build(16'h0001, 16'h0001, 32'd13, 1'b0);
        push_writes(4, 1);
        fifo_q.push_back({2'b01, 16'h0001, 16'h0004, 8'h80, 32'd13});
        resp_q.push_back(20'h10001);
        send_all();
        fdram_rd_ptr = 4'd5;

        // Channel 2 full: good CRC -> status 5, bad CRC -> status 0 wins.
        fififo_full = 2'b10;
        pay_q = {8'hD0, 8'hD1};
        build(16'h0002, 16'h6666, 32'd14, 1'b0);
        push_writes(5, 2);
        resp_q.push_back(20'h56666);
        send_all();
        build(16'h0002, 16'h6666, 32'd14, 1'b1);
        push_writes(5, 2);
        resp_q.push_back(20'h06666);
        send_all();
        fififo_full = 2'b00;

        // Invalid type: parsed, written, then dropped without a response.
        pay_q = {8'h77};
        build(16'h0003, 16'h7777, 32'd13, 1'b0);
        push_writes(5, 1);
        send_all();

        // Reset in the middle of a payload.
        pay_q = {8'hE0, 8'hE1, 8'hE2, 8'hE3};
        build(16'h0001, 16'h0E0E, 32'd16, 1'b0);
        push_writes(5, 2);
        send_n(14);
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1 check_outputs_zero("midrst");
        fdram_rd_ptr = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        pay_q = {8'h01, 8'h02, 8'h03};
        build(16'h0001, 16'h0F0F, 32'd15, 1'b0);
        push_writes(0, 3);
        fifo_q.push_back({2'b01, 16'h0F0F, 16'h0000, 8'h80, 32'd15});
        resp_q.push_back(20'h10F0F);
        send_all();

        repeat (20) @(negedge clk);
        check("resp_pending",  80'(resp_q.size()), 80'(0));
        check("fifo_pending",  80'(fifo_q.size()), 80'(0));
        check("ramwr_pending", 80'(wr_q.size()), 80'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
